// File: rtl/dmem_store_buffer_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : dmem_store_buffer_responder_if
// Description : Bus bundle between the core (or bench) and the memory
//               responder: instruction fetch port, data load/store port and
//               the preload (loader) write port.
//               master : core side, drives commands/addresses/store data,
//                        receives fetched instruction and load data.
//               slave  : memory side, the responder.
// Revision    : 1.0 - initial release
// ============================================================================
interface dmem_store_buffer_responder_if;
  logic [1:0]  im_command;
  logic [31:0] pc_addr;
  logic [31:0] instruction;
  logic [1:0]  proc2Dmem_command;
  logic [31:0] proc2Dmem_addr;
  logic [31:0] proc2mem_data;
  logic [31:0] mem2proc_data;
  logic        ld_wr_en;
  logic [31:0] ld_addr;
  logic [31:0] ld_data;

  modport master (
    output im_command, pc_addr,
    output proc2Dmem_command, proc2Dmem_addr, proc2mem_data,
    output ld_wr_en, ld_addr, ld_data,
    input  instruction, mem2proc_data
  );

  modport slave (
    input  im_command, pc_addr,
    input  proc2Dmem_command, proc2Dmem_addr, proc2mem_data,
    input  ld_wr_en, ld_addr, ld_data,
    output instruction, mem2proc_data
  );
endinterface
`default_nettype wire

// File: rtl/dmem_store_buffer_responder.sv
`default_nettype none
// ============================================================================
// Module      : dmem_store_buffer_responder
// Description : Zero-latency memory responder for the core's instruction and
//               data buses. Stores go through a circular store buffer that
//               drains one entry per cycle into a single-write-port word
//               array; data loads forward from the youngest matching
//               buffered store. The loader port wins the write port over
//               the drain, and it keeps working while rst is high.
// Ports       : clk, rst       - clock, synchronous active-high reset
//               bus (slave)    - fetch / data / loader bus bundle
//               sb_count       - occupied store-buffer entries (registered)
//               sb_empty       - sb_count == 0 (registered)
//               sb_overflow    - sticky: a store was dropped (registered)
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_store_buffer_responder #(
  parameter int MEM_WORDS = 1024,
  parameter int SB_DEPTH  = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  dmem_store_buffer_responder_if.slave bus,
  output logic [$clog2(SB_DEPTH):0] sb_count,
  output logic                      sb_empty,
  output logic                      sb_overflow
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam int PW = $clog2(SB_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [1:0]    BUS_LOAD   = 2'b01;
  localparam logic [1:0]    BUS_STORE  = 2'b10;
  localparam logic [CW-1:0] FULL_COUNT = CW'(SB_DEPTH);

  // Word array: not reset, single write port shared by loader and drain.
  logic [31:0]   mem [MEM_WORDS];

  // Store buffer storage and bookkeeping.
  logic [AW-1:0]       sb_idx  [SB_DEPTH];
  logic [31:0]         sb_data [SB_DEPTH];
  logic [SB_DEPTH-1:0] sb_valid;
  logic [SB_DEPTH-1:0] next_valid;
  logic [PW-1:0]       head;
  logic [PW-1:0]       tail;
  logic [CW-1:0]       next_count;

  logic [AW-1:0] pc_idx;
  logic [AW-1:0] d_idx;
  logic [AW-1:0] ld_idx;
  logic          drain;
  logic          store_req;
  logic          full;
  logic          enq;
  logic          drop;
  logic          fwd_hit;
  logic [31:0]   fwd_data;
  logic [PW-1:0] pos;
  logic          unused_addr_bits;

  assign pc_idx = bus.pc_addr[AW+1:2];
  assign d_idx  = bus.proc2Dmem_addr[AW+1:2];
  assign ld_idx = bus.ld_addr[AW+1:2];

  // Byte-offset and high address bits are deliberately ignored (aliasing).
  assign unused_addr_bits = ^{bus.pc_addr[1:0], bus.pc_addr[31:AW+2],
                              bus.proc2Dmem_addr[1:0], bus.proc2Dmem_addr[31:AW+2],
                              bus.ld_addr[1:0], bus.ld_addr[31:AW+2]};

  // Drain only when the loader is not using the write port.
  assign drain     = (sb_count != '0) && !bus.ld_wr_en;
  assign store_req = (bus.proc2Dmem_command == BUS_STORE);
  assign full      = (sb_count == FULL_COUNT);
  // A full buffer still accepts a store when the head leaves on the same edge.
  assign enq       = store_req && (!full || drain);
  assign drop      = store_req && full && !drain;

  always_comb begin
    next_valid = sb_valid;
    if (drain) next_valid[head] = 1'b0;
    // Set after clear: when full, tail == head and the new entry must stay valid.
    if (enq)   next_valid[tail] = 1'b1;
  end

  always_comb begin
    next_count = sb_count;
    case ({enq, drain})
      2'b10:   next_count = sb_count + 1'b1;
      2'b01:   next_count = sb_count - 1'b1;
      default: next_count = sb_count;
    endcase
  end

  // Walk entries from oldest to youngest so the last match is the youngest.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    pos      = '0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      pos = head + PW'(i);
      if (sb_valid[pos] && (sb_idx[pos] == d_idx)) begin
        fwd_hit  = 1'b1;
        fwd_data = sb_data[pos];
      end
    end
  end

  // Combinational read ports.
  assign bus.instruction   = (bus.im_command == BUS_LOAD) ? mem[pc_idx] : '0;
  assign bus.mem2proc_data = (bus.proc2Dmem_command != BUS_LOAD) ? '0 :
                             (fwd_hit ? fwd_data : mem[d_idx]);

  // Array write port: loader has priority and is honoured during reset;
  // the drain is suppressed by reset because reset discards pending stores.
  always_ff @(posedge clk) begin
    if (bus.ld_wr_en) begin
      mem[ld_idx] <= bus.ld_data;
    end else if (drain && !rst) begin
      mem[sb_idx[head]] <= sb_data[head];
    end
  end

  // Store buffer control and registered status.
  always_ff @(posedge clk) begin
    if (rst) begin
      head        <= '0;
      tail        <= '0;
      sb_valid    <= '0;
      sb_count    <= '0;
      sb_empty    <= 1'b1;
      sb_overflow <= 1'b0;
    end else begin
      if (drain) head <= head + 1'b1;
      if (enq) begin
        tail          <= tail + 1'b1;
        sb_idx[tail]  <= d_idx;
        sb_data[tail] <= bus.proc2mem_data;
      end
      sb_valid <= next_valid;
      sb_count <= next_count;
      sb_empty <= (next_count == '0);
      if (drop) sb_overflow <= 1'b1;
    end
  end

endmodule
`default_nettype wire
